// File: rtl/ad_pnmon_pkg.sv
// Shared constants and types for the multi-lane PN monitor: polynomial degrees/taps,
// sequence-select encodings and the lock state enum.
package ad_pnmon_pkg;

  localparam int PN9_DEG    = 9;
  localparam int PN9_TAP    = 5;
  localparam int PN23_DEG   = 23;
  localparam int PN23_TAP   = 18;
  localparam int PN_MAX_DEG = 23;

  localparam int POLY_PN9  = 0;
  localparam int POLY_PN23 = 1;

  localparam logic [3:0] PNSEL_PN9  = 4'd0;
  localparam logic [3:0] PNSEL_PN23 = 4'd1;

  typedef enum logic {
    ST_OOS  = 1'b0,
    ST_SYNC = 1'b1
  } pn_state_e;

  function automatic int pn_deg(input int poly_sel);
    return (poly_sel == POLY_PN23) ? PN23_DEG : PN9_DEG;
  endfunction

  function automatic int pn_tap(input int poly_sel);
    return (poly_sel == POLY_PN23) ? PN23_TAP : PN9_TAP;
  endfunction

  function automatic logic pnsel_supported(input logic [3:0] sel);
    return (sel == PNSEL_PN9) || (sel == PNSEL_PN23);
  endfunction

endpackage

// File: rtl/ad_pnmon_mlane_pngen.sv
// Combinational LFSR advance: from the last DEG sequence bits (state_in[0] = most recent)
// produce the next W sequence bits, seq_out[0] being the earliest of them.
module ad_pngen_adv
  import ad_pnmon_pkg::*;
#(
  parameter int POLY_SEL = 0,
  parameter int W        = 48
) (
  input  logic [pn_deg(POLY_SEL)-1:0] state_in,
  output logic [W-1:0]                seq_out
);

  localparam int DEG = pn_deg(POLY_SEL);
  localparam int TAP = pn_tap(POLY_SEL);

  // s[n] = s[n-DEG] ^ s[n-TAP], non-inverted
  always_comb begin
    logic [DEG-1:0] st;
    logic           fb;
    st      = state_in;
    seq_out = '0;
    for (int k = 0; k < W; k++) begin
      fb         = st[DEG-1] ^ st[TAP-1];
      seq_out[k] = fb;
      st         = {st[DEG-2:0], fb};
    end
  end

endmodule

// File: rtl/ad_pnmon_mlane.sv
// Multi-lane PN9/PN23 monitor: self-seeds from received beats, locks/unlocks with a
// run-length hysteresis FSM, and keeps a saturating error counter.
module ad_pnmon_mlane
  import ad_pnmon_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int SAMPLES       = 4,
  parameter int OOS_THRESHOLD = 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                          adc_clk,
  input  logic                          adc_rstn,
  input  logic                          adc_valid,
  input  logic [SAMPLES*DATA_WIDTH-1:0] adc_data,
  input  logic [3:0]                    adc_pnseq_sel,
  input  logic                          adc_pn_clr,
  output logic                          adc_pn_err,
  output logic                          adc_pn_oos,
  output logic [CNT_WIDTH-1:0]          adc_pn_err_cnt
);

  localparam int W     = DATA_WIDTH * SAMPLES;
  localparam int RUN_W = $clog2(OOS_THRESHOLD + 1);

  localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(OOS_THRESHOLD - 1);
  localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (W < PN_MAX_DEG) begin : g_width_check
    $error("ad_pnmon_mlane: DATA_WIDTH*SAMPLES must be at least 23");
  end

  // Word <-> sequence order: sample 0 first, MSB first within a sample. The map is its own inverse.
  function automatic logic [W-1:0] bit_reorder(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) begin
      r[k] = v[(k / DATA_WIDTH) * DATA_WIDTH + DATA_WIDTH - 1 - (k % DATA_WIDTH)];
    end
    return r;
  endfunction

  function automatic logic [PN_MAX_DEG-1:0] seq_tail(input logic [W-1:0] seq);
    logic [PN_MAX_DEG-1:0] st;
    for (int i = 0; i < PN_MAX_DEG; i++) begin
      st[i] = seq[W - 1 - i];
    end
    return st;
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [W-1:0]          s1_data_q, s1_data_d;
  logic [3:0]            sel_q, sel_d;
  logic [W-1:0]          exp_q, exp_d;
  pn_state_e             fsm_q, fsm_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  err_s2_q, err_s2_d;
  logic                  err_q, err_d;
  logic                  oos_q, oos_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [PN_MAX_DEG-1:0] rx_state, exp_state;
  logic [W-1:0]          seed_seq_pn9, seed_seq_pn23, free_seq_pn9, free_seq_pn23;
  logic [W-1:0]          seed_word, free_word;
  logic                  match, sel_force, poly_pn23;

  assign rx_state  = seq_tail(bit_reorder(s1_data_q));
  assign exp_state = seq_tail(bit_reorder(exp_q));

  ad_pngen_adv #(.POLY_SEL(POLY_PN9), .W(W)) u_seed_pn9 (
    .state_in (rx_state[PN9_DEG-1:0]),
    .seq_out  (seed_seq_pn9)
  );
  ad_pngen_adv #(.POLY_SEL(POLY_PN23), .W(W)) u_seed_pn23 (
    .state_in (rx_state),
    .seq_out  (seed_seq_pn23)
  );
  ad_pngen_adv #(.POLY_SEL(POLY_PN9), .W(W)) u_free_pn9 (
    .state_in (exp_state[PN9_DEG-1:0]),
    .seq_out  (free_seq_pn9)
  );
  ad_pngen_adv #(.POLY_SEL(POLY_PN23), .W(W)) u_free_pn23 (
    .state_in (exp_state),
    .seq_out  (free_seq_pn23)
  );

  assign poly_pn23 = (sel_q == PNSEL_PN23);
  assign seed_word = bit_reorder(poly_pn23 ? seed_seq_pn23 : seed_seq_pn9);
  assign free_word = bit_reorder(poly_pn23 ? free_seq_pn23 : free_seq_pn9);
  assign match     = (s1_data_q == exp_q);
  // A freshly changed or unsupported selection discards the lock and the expected word.
  assign sel_force = (adc_pnseq_sel != sel_q) || !pnsel_supported(sel_q);

  always_comb begin
    s1_valid_d = adc_valid;
    s1_data_d  = adc_valid ? adc_data : s1_data_q;
    sel_d      = adc_pnseq_sel;
  end

  always_comb begin
    fsm_d    = fsm_q;
    run_d    = run_q;
    exp_d    = exp_q;
    err_s2_d = 1'b0;
    if (sel_force) begin
      fsm_d = ST_OOS;
      run_d = '0;
      exp_d = '0;
    end else if (s1_valid_q) begin
      case (fsm_q)
        ST_OOS: begin
          exp_d = seed_word;
          if (!match) begin
            run_d = '0;
          end else if (run_q == RUN_LAST) begin
            fsm_d = ST_SYNC;
            run_d = '0;
          end else begin
            run_d = run_q + RUN_ONE;
          end
        end
        default: begin
          exp_d    = free_word;
          err_s2_d = !match;
          if (match) begin
            run_d = '0;
          end else if (run_q == RUN_LAST) begin
            fsm_d = ST_OOS;
            run_d = '0;
          end else begin
            run_d = run_q + RUN_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    err_d = err_s2_q;
    oos_d = (fsm_q == ST_OOS);
    cnt_d = cnt_q;
    if (adc_pn_clr) begin
      cnt_d = '0;
    end else if (err_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sel_q      <= PNSEL_PN9;
      exp_q      <= '0;
      fsm_q      <= ST_OOS;
      run_q      <= '0;
      err_s2_q   <= 1'b0;
      err_q      <= 1'b0;
      oos_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      sel_q      <= sel_d;
      exp_q      <= exp_d;
      fsm_q      <= fsm_d;
      run_q      <= run_d;
      err_s2_q   <= err_s2_d;
      err_q      <= err_d;
      oos_q      <= oos_d;
      cnt_q      <= cnt_d;
    end
  end

  assign adc_pn_err     = err_q;
  assign adc_pn_oos     = oos_q;
  assign adc_pn_err_cnt = cnt_q;

endmodule

// File: tb/tb_ad_pnmon_mlane.sv
// Directed bench for ad_pnmon_mlane: lock, single errors, loss of lock, counter
// saturation/clear priority, sequence-select changes, gapped valid and async reset.
module tb_ad_pnmon_mlane;

  localparam int DW  = 12;
  localparam int NS  = 4;
  localparam int W   = DW * NS;
  localparam int THR = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [W-1:0]  data;
  logic [3:0]    sel;
  logic          clr;
  logic          err;
  logic          oos;
  logic [CW-1:0] cnt;

  int n_checks   = 0;
  int n_pass     = 0;
  int err_pulses = 0;
  int base;

  bit pn_bits[$];
  int m_deg;
  int m_tap;

  ad_pnmon_mlane #(
    .DATA_WIDTH    (DW),
    .SAMPLES       (NS),
    .OOS_THRESHOLD (THR),
    .CNT_WIDTH     (CW)
  ) dut (
    .adc_clk        (clk),
    .adc_rstn       (rst_n),
    .adc_valid      (valid),
    .adc_data       (data),
    .adc_pnseq_sel  (sel),
    .adc_pn_clr     (clr),
    .adc_pn_err     (err),
    .adc_pn_oos     (oos),
    .adc_pn_err_cnt (cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n && err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference PN stream: s[n] = s[n-deg] ^ s[n-tap], seeded with all ones
  task automatic pn_restart(input int deg, input int tap);
    m_deg = deg;
    m_tap = tap;
    pn_bits.delete();
    repeat (deg) pn_bits.push_back(1'b1);
  endtask

  task automatic pn_word(output logic [W-1:0] w);
    bit b;
    int n;
    w = '0;
    for (int k = 0; k < W; k++) begin
      n = pn_bits.size();
      b = pn_bits[n - m_deg] ^ pn_bits[n - m_tap];
      pn_bits.push_back(b);
      void'(pn_bits.pop_front());
      w[(k / DW) * DW + DW - 1 - (k % DW)] = b;
    end
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0);
  endtask

  task automatic good_beats(input int n);
    logic [W-1:0] w;
    repeat (n) begin
      pn_word(w);
      cyc(1'b1, w);
    end
  endtask

  task automatic bad_beat(input int bitpos);
    logic [W-1:0] w;
    pn_word(w);
    w[bitpos] = ~w[bitpos];
    cyc(1'b1, w);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    sel   = 4'd0;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oos", oos, 1);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // PN9 clean stream: first beat seeds, beats 2..17 are the 16 matches
    pn_restart(9, 5);
    good_beats(16);
    idle(2);
    chk("t1_oos_after_16", oos, 1);
    good_beats(1);
    idle(1);
    chk("t1_oos_latency1", oos, 1);
    idle(1);
    chk("t1_lock_after_17", oos, 0);
    idle(1);
    chk("t1_no_err", err_pulses, 0);

    // PN9 -> PN23 while locked
    sel = 4'd1;
    idle(2);
    chk("t5_sel_oos", oos, 1);
    idle(1);
    chk("t5_sel_no_err", err_pulses, 0);
    pn_restart(23, 18);
    good_beats(17);
    idle(2);
    chk("t5_pn23_lock", oos, 0);

    // single bit flip while locked
    pulse_clr();
    idle(1);
    chk("t2_cnt_cleared", cnt, 0);
    base = err_pulses;
    bad_beat(5);
    idle(1);
    chk("t2_err_not_yet", err, 0);
    idle(1);
    chk("t2_err_pulse", err, 1);
    idle(1);
    chk("t2_err_one_cycle", err, 0);
    chk("t2_cnt_one", cnt, 1);
    good_beats(4);
    idle(3);
    chk("t2_still_locked", oos, 0);
    chk("t2_pulse_count", err_pulses - base, 1);

    // 16 consecutive bad beats lose lock, then a clean stream relocks
    base = err_pulses;
    for (int i = 0; i < THR - 1; i++) bad_beat(i * 3);
    idle(2);
    chk("t3_locked_after_15_bad", oos, 0);
    bad_beat(47);
    idle(2);
    chk("t3_oos_after_16_bad", oos, 1);
    idle(1);
    chk("t3_pulse_count", err_pulses - base, 16);
    chk("t3_cnt_saturated", cnt, 15);
    good_beats(15);
    idle(2);
    chk("t3_oos_after_15_good", oos, 1);
    good_beats(1);
    idle(2);
    chk("t3_relock", oos, 0);
    idle(1);
    chk("t3_no_err_while_oos", err_pulses - base, 16);

    // counter saturation from zero, then clear priority over increment
    pulse_clr();
    idle(1);
    chk("t4_cnt_cleared", cnt, 0);
    for (int i = 0; i < 20; i++) begin
      bad_beat(i);
      good_beats(1);
    end
    idle(3);
    chk("t4_cnt_hold_15", cnt, 15);
    chk("t4_still_locked", oos, 0);
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      bad_beat(10 + i);
      good_beats(1);
    end
    idle(3);
    chk("t4_cnt_three", cnt, 3);
    bad_beat(7);
    idle(2);
    chk("t4_err_high", err, 1);
    pulse_clr();
    chk("t4_clr_priority", cnt, 0);
    idle(2);
    chk("t4_cnt_stays_0", cnt, 0);

    // unsupported select keeps the monitor out of sync
    sel = 4'd7;
    idle(2);
    chk("t5_sel7_oos", oos, 1);
    base = err_pulses;
    good_beats(20);
    idle(3);
    chk("t5_sel7_stays_oos", oos, 1);
    chk("t5_sel7_no_err", err_pulses - base, 0);

    // PN9 with valid on every other cycle
    sel = 4'd0;
    idle(2);
    pn_restart(9, 5);
    for (int i = 0; i < 16; i++) begin
      good_beats(1);
      idle(1);
    end
    idle(1);
    chk("t6_oos_after_16", oos, 1);
    good_beats(1);
    idle(2);
    chk("t6_gapped_lock", oos, 0);
    bad_beat(0);
    idle(3);
    chk("t6_cnt_one", cnt, 1);

    // asynchronous reset mid-stream while an error pulse is on the output
    bad_beat(3);
    idle(2);
    chk("t6_err_before_rst", err, 1);
    valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_oos", oos, 1);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_cnt", cnt, 0);
    @(posedge clk);
    #1;
    chk("t6_rst_hold_oos", oos, 1);
    valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    chk("t6_post_rst_oos", oos, 1);
    chk("t6_post_rst_cnt", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
